fpu_addsub_unit: RTL and testbench

Responder-side execution unit for FP32 add/subtract requests from the issue logic. Accepts operand pairs with a valid/ready handshake and turns subtract into add by flipping the x2 sign. Drives the pipelined adder fadd_p2 and tracks in-flight operations in a valid/tag shift register. Buffers results in a small output FIFO so downstream backpressure never drops a result; issue is credit-limited.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fadd_p2.sv | 129 ++++++++++++
 rtl/fpu_resp_fifo.sv | 45 ++++
 rtl/fpu_addsub_unit.sv | 101 ++++++++++
 tb/tb_fpu_addsub_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 types and constants for the add/subtract execution unit.
package fpu_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  localparam int          SIGN_BIT      = 31;
  localparam logic [7:0]  EXP_MAX       = 8'hFF;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction
endpackage

// File: rtl/fadd_p2.sv
// Two-stage FP32 adder, round-to-nearest-even, denormals flushed to zero.
module fadd_p2
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);
  fp32_t       a, b;
  logic        swap, big_sign, eff_sub, a_nan, b_nan, a_inf, b_inf, spec;
  logic [7:0]  big_exp, sml_exp, d;
  logic [23:0] ma, mb, mbig, msml;
  logic [49:0] ext;
  logic [26:0] sml_al;
  logic [27:0] sum;
  logic [31:0] spec_y;

  logic [27:0] s1_sum;
  logic [7:0]  s1_exp;
  logic        s1_sign, s1_sub, s1_spec;
  logic [31:0] s1_spec_y;

  logic [4:0]  lz;
  logic [26:0] norm;
  logic [9:0]  e;
  logic        up;
  logic [24:0] rnd;
  logic [22:0] frac;
  logic [31:0] y_n;
  logic        ovf_n;

  // Stage 1: order operands by magnitude, align the smaller one, add or subtract.
  always_comb begin
    a       = x1;
    b       = x2;
    ma      = (a.exp == 8'd0) ? 24'd0 : {1'b1, a.mant};
    mb      = (b.exp == 8'd0) ? 24'd0 : {1'b1, b.mant};
    swap    = {b.exp, b.mant} > {a.exp, a.mant};
    big_sign = swap ? b.sign : a.sign;
    big_exp = swap ? b.exp : a.exp;
    sml_exp = swap ? a.exp : b.exp;
    mbig    = swap ? mb : ma;
    msml    = swap ? ma : mb;
    d       = big_exp - sml_exp;
    ext     = {msml, 26'd0} >> d;
    if (d > 8'd26) begin
      sml_al = {26'd0, |msml};
    end else begin
      sml_al = {ext[49:24], ext[23] | (|ext[22:0])};
    end
    eff_sub = a.sign ^ b.sign;
    if (eff_sub) begin
      sum = {1'b0, mbig, 3'd0} - {1'b0, sml_al};
    end else begin
      sum = {1'b0, mbig, 3'd0} + {1'b0, sml_al};
    end
    a_nan = (a.exp == EXP_MAX) && (a.mant != 23'd0);
    b_nan = (b.exp == EXP_MAX) && (b.mant != 23'd0);
    a_inf = (a.exp == EXP_MAX) && (a.mant == 23'd0);
    b_inf = (b.exp == EXP_MAX) && (b.mant == 23'd0);
    spec  = a_nan | b_nan | a_inf | b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      spec_y = FP32_QNAN;
    end else if (a_inf) begin
      spec_y = {a.sign, EXP_MAX, 23'd0};
    end else begin
      spec_y = {b.sign, EXP_MAX, 23'd0};
    end
  end

  // Stage 2: normalise, round to nearest even, detect overflow and underflow.
  always_comb begin
    lz = lzc27(s1_sum[26:0]);
    if (s1_sum[27]) begin
      norm = {s1_sum[27:2], s1_sum[1] | s1_sum[0]};
      e    = {2'b00, s1_exp} + 10'd1;
    end else begin
      norm = s1_sum[26:0] << lz;
      e    = {2'b00, s1_exp} - {5'd0, lz};
    end
    up   = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd  = {1'b0, norm[26:3]} + {24'd0, up};
    frac = rnd[24] ? rnd[23:1] : rnd[22:0];
    if (rnd[24]) begin
      e = e + 10'd1;
    end else begin
      e = e;
    end
    ovf_n = 1'b0;
    if (s1_spec) begin
      y_n = s1_spec_y;
    end else if (s1_sum == 28'd0) begin
      y_n = s1_sub ? FP32_POS_ZERO : {s1_sign, 31'd0};
    end else if (e[9] || (e == 10'd0)) begin
      y_n = {s1_sign, 31'd0};
    end else if (e >= 10'd255) begin
      y_n   = {s1_sign, EXP_MAX, 23'd0};
      ovf_n = 1'b1;
    end else begin
      y_n = {s1_sign, e[7:0], frac};
    end
  end

  // Pipeline registers for both stages.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_sum    <= 28'd0;
      s1_exp    <= 8'd0;
      s1_sign   <= 1'b0;
      s1_sub    <= 1'b0;
      s1_spec   <= 1'b0;
      s1_spec_y <= FP32_POS_ZERO;
      y         <= FP32_POS_ZERO;
      ovf       <= 1'b0;
    end else begin
      s1_sum    <= sum;
      s1_exp    <= big_exp;
      s1_sign   <= big_sign;
      s1_sub    <= eff_sub;
      s1_spec   <= spec;
      s1_spec_y <= spec_y;
      y         <= y_n;
      ovf       <= ovf_n;
    end
  end
endmodule

// File: rtl/fpu_resp_fifo.sv
// Synchronous result FIFO; head is read straight from storage, which is cleared on reset.
module fpu_resp_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= PW'(0);
      rd_ptr <= PW'(0);
      count  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) mem[i] <= {W{1'b0}};
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fpu_addsub_unit.sv
// FP32 add/subtract execution unit: handshake, sign flip, in-flight tracking,
// credit-limited issue and a result FIFO that absorbs downstream backpressure.
module fpu_addsub_unit
  import fpu_pkg::*;
#(
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sub,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_y,
  output logic             resp_ovf,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = 33 + TAG_W;

  logic             accept, push, pop;
  logic [31:0]      op_x1, op_x2, add_y;
  logic             add_ovf;
  logic [LAT:0]     vld_sr;
  logic [TAG_W-1:0] tag_sr [LAT+1];
  logic [CW-1:0]    inflight, count;
  logic [CW:0]      credits;
  logic [DW-1:0]    head;

  // Every accepted op owns a FIFO slot until popped, so the FIFO can never overflow.
  assign credits    = {1'b0, inflight} + {1'b0, count};
  assign req_ready  = ~rst & (credits < (CW+1)'(FIFO_DEPTH));
  assign accept     = req_valid & req_ready;
  assign push       = vld_sr[LAT];
  assign resp_valid = ~rst & (count != CW'(0));
  assign pop        = resp_valid & resp_ready;
  assign busy       = ~rst & ((inflight != CW'(0)) | (count != CW'(0)));
  assign {resp_y, resp_ovf, resp_tag} = head;

  // Operand registers; subtraction becomes addition of the negated second operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_x1 <= FP32_POS_ZERO;
      op_x2 <= FP32_POS_ZERO;
    end else if (accept) begin
      op_x1 <= req_x1;
      op_x2 <= {req_x2[SIGN_BIT] ^ req_sub, req_x2[SIGN_BIT-1:0]};
    end
  end

  // Valid/tag shift registers aligned with the adder pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= {(LAT+1){1'b0}};
      for (int i = 0; i <= LAT; i++) tag_sr[i] <= {TAG_W{1'b0}};
    end else begin
      vld_sr <= {vld_sr[LAT-1:0], accept};
      if (accept) tag_sr[0] <= req_tag;
      for (int i = 1; i <= LAT; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  // Accepted-but-not-yet-buffered counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= CW'(0);
    end else begin
      case ({accept, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  fadd_p2 u_fadd (
    .clk  (clk),
    .rstn (~rst),
    .x1   (op_x1),
    .x2   (op_x2),
    .y    (add_y),
    .ovf  (add_ovf)
  );

  fpu_resp_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({add_y, add_ovf, tag_sr[LAT]}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );
endmodule

// File: tb/tb_fpu_addsub_unit.sv
// Directed bench with a scoreboard fed by an independent real-arithmetic FP32 model.
module tb_fpu_addsub_unit;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_sub, resp_valid, resp_ready, resp_ovf, busy;
  logic [31:0] req_x1, req_x2, resp_y;
  logic [3:0]  req_tag, resp_tag;

  int errors = 0, checks = 0, accepted = 0, popped = 0;
  logic [36:0] sb [$];
  logic [36:0] mon_e;
  logic [32:0] mon_r;

  always #5 clk = ~clk;

  fpu_addsub_unit #(.LAT(2), .FIFO_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_y(resp_y), .resp_ovf(resp_ovf), .resp_tag(resp_tag),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e11;
    if (f[30:23] == 8'd0) return 0.0;
    e11 = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e11, f[22:0], 29'd0});
  endfunction

  // Returns {ovf, y}; exact for the operand ranges used here, then rounded once to nearest even.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    real         r;
    logic [63:0] d;
    int          fe;
    logic [23:0] m;
    logic [24:0] mr;
    r = f2r(a) + f2r(b);
    if (r == 0.0) return 33'd0;
    d  = $realtobits(r);
    fe = int'(d[62:52]) - 896;
    m  = {1'b1, d[51:29]};
    mr = {1'b0, m} + {24'd0, d[28] & ((|d[27:0]) | m[0])};
    if (mr[24]) begin
      fe++;
      mr = mr >> 1;
    end
    if (fe >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
    return {1'b0, d[63], 8'(fe), mr[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
  endfunction

  // Scoreboard: record expected results at accept, compare at pop.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (resp_valid && resp_ready) begin
        popped++;
        check("resp_has_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("sb_y", resp_y, mon_e[35:4]);
          check("sb_ovf", resp_ovf, mon_e[36]);
          check("sb_tag", resp_tag, mon_e[3:0]);
        end
      end
      if (req_valid && req_ready) begin
        accepted++;
        mon_r = ref_add(req_x1, {req_x2[31] ^ req_sub, req_x2[30:0]});
        sb.push_back({mon_r[32], mon_r[31:0], req_tag});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    req_valid = 1'b1; req_sub = s; req_x1 = a; req_x2 = b; req_tag = t;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin tick(1); n++; end
    check("ready_timeout", req_ready, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(1); n++; end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic run_one(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, input logic [31:0] ey, input logic eovf);
    int n = 0;
    drive(s, a, b, t);
    wait_ready();
    tick(1);
    req_valid = 1'b0;
    while (!resp_valid && n < 10) begin tick(1); n++; end
    check("dir_valid", resp_valid, 1'b1);
    check("dir_y", resp_y, ey);
    check("dir_ovf", resp_ovf, eovf);
    check("dir_tag", resp_tag, t);
    tick(1);
  endtask

  initial begin
    int base_a, base_p;
    rst = 1'b1; req_valid = 1'b0; req_sub = 1'b0; req_x1 = 32'd0; req_x2 = 32'd0;
    req_tag = 4'd0; resp_ready = 1'b0;
    tick(2);
    check("rst_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(1);
    check("post_rst_ready", req_ready, 1'b1);
    check("post_rst_valid", resp_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_y", resp_y, 32'd0);
    check("post_rst_ovf", resp_ovf, 1'b0);
    check("post_rst_tag", resp_tag, 4'd0);

    // latency: 3.0 - 1.0 with tag 5
    resp_ready = 1'b1;
    drive(1'b1, 32'h4040_0000, 32'h3F80_0000, 4'd5);
    tick(1);
    req_valid = 1'b0;
    check("lat_c1_valid", resp_valid, 1'b0);
    check("lat_c1_busy", busy, 1'b1);
    tick(1); check("lat_c2_valid", resp_valid, 1'b0);
    tick(1); check("lat_c3_valid", resp_valid, 1'b0);
    tick(1); check("lat_c4_valid", resp_valid, 1'b1);
    check("lat_y", resp_y, 32'h4000_0000);
    check("lat_ovf", resp_ovf, 1'b0);
    check("lat_tag", resp_tag, 4'd5);
    tick(1);

    run_one(1'b0, 32'h4040_0000, 32'h3F80_0000, 4'd6, 32'h4080_0000, 1'b0);
    run_one(1'b1, 32'h3F80_0000, 32'h3F80_0000, 4'd7, 32'h0000_0000, 1'b0);
    run_one(1'b1, 32'h7F7F_FFFF, 32'hFF7F_FFFF, 4'd8, 32'h7F80_0000, 1'b1);

    // backpressure: six cycles of offered requests with no consumer
    resp_ready = 1'b0;
    base_a = accepted;
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom_range(0, 1)), rand_fp(), rand_fp(), 4'(i));
      tick(1);
    end
    req_valid = 1'b0;
    check("bp_accepted", 64'(accepted - base_a), 64'd4);
    check("bp_ready_low", req_ready, 1'b0);
    tick(4);
    check("bp_head_valid", resp_valid, 1'b1);
    check("bp_head_tag", resp_tag, 4'd0);
    check("bp_ready_full", req_ready, 1'b0);
    resp_ready = 1'b1;
    base_p = popped;
    wait_idle(20);
    check("bp_popped", 64'(popped - base_p), 64'd4);
    check("bp_ready_back", req_ready, 1'b1);

    // streaming: sixteen requests with a free-running consumer
    base_a = accepted;
    base_p = popped;
    for (int i = 0; i < 16; i++) begin
      drive(1'($urandom_range(0, 1)), rand_fp(), rand_fp(), 4'(i));
      wait_ready();
      tick(1);
    end
    req_valid = 1'b0;
    wait_idle(40);
    check("stream_accepted", 64'(accepted - base_a), 64'd16);
    check("stream_popped", 64'(popped - base_p), 64'd16);

    // reset with one result buffered and two in flight
    resp_ready = 1'b0;
    drive(1'b0, rand_fp(), rand_fp(), 4'd9);
    wait_ready();
    tick(1);
    req_valid = 1'b0;
    tick(3);
    check("mid_buffered", resp_valid, 1'b1);
    drive(1'b0, rand_fp(), rand_fp(), 4'd10); tick(1);
    drive(1'b1, rand_fp(), rand_fp(), 4'd11); tick(1);
    req_valid = 1'b0;
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", resp_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", req_ready, 1'b0);
    tick(1);
    rst = 1'b0;
    #1;
    check("after_rst_valid", resp_valid, 1'b0);
    check("after_rst_busy", busy, 1'b0);
    check("after_rst_ready", req_ready, 1'b1);
    check("after_rst_y", resp_y, 32'd0);
    check("after_rst_tag", resp_tag, 4'd0);
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("no_stale", resp_valid, 1'b0);
    end
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
